// File: rtl/irq_pkg.sv
// Shared types and register offsets for the interrupt controller.
package irq_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StAssert,
        StService
    } irq_state_e;

    localparam logic [15:0] OffPending = 16'd0;
    localparam logic [15:0] OffMask    = 16'd1;
    localparam logic [15:0] OffMode    = 16'd2;
    localparam logic [15:0] OffStatus  = 16'd3;

endpackage

// File: rtl/irq_sync_edge.sv
// Two-flop synchroniser for one asynchronous interrupt source, plus rising-edge detect.
module irq_sync_edge (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic level_o,
    output logic rise_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign level_o = sync_q;
    assign rise_o  = sync_q & ~prev_q;

endmodule

// File: rtl/irq_controller.sv
// Prioritised interrupt controller: per-channel edge/level latching, masking,
// and an IDLE/ASSERT/SERVICE handshake with the CPU.
module irq_controller #(
    parameter int unsigned NUM_CH    = 4,
    parameter logic [15:0] BASE_ADDR = 16'hFF10
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [NUM_CH-1:0] src_irq_i,
    input  logic [15:0]       waddr_i,
    input  logic [15:0]       wdata_i,
    input  logic              wenable_i,
    input  logic [15:0]       raddr_i,
    output logic [15:0]       rdata_o,
    output logic              irq_o,
    input  logic              reset_irq_i,
    output logic [3:0]        vector_o
);

    import irq_pkg::*;

    logic [NUM_CH-1:0] lvl, rise, set_bits, clr_bits, enabled, vec_onehot;
    logic [NUM_CH-1:0] pend_q, pend_d, mask_q, mode_q;
    irq_state_e        state_q;
    logic              irq_q;
    logic [3:0]        vector_q;
    logic [3:0]        win_idx;
    logic              win_valid, vec_pending, ack;
    logic              wr_pend, wr_mask, wr_mode, wr_status;
    logic [15:0]       pend_ext, mask_ext, mode_ext;
    logic              unused_wdata;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_sync
        irq_sync_edge u_sync (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .d_i     (src_irq_i[i]),
            .level_o (lvl[i]),
            .rise_o  (rise[i])
        );
    end

    assign wr_pend   = wenable_i && (waddr_i == BASE_ADDR + OffPending);
    assign wr_mask   = wenable_i && (waddr_i == BASE_ADDR + OffMask);
    assign wr_mode   = wenable_i && (waddr_i == BASE_ADDR + OffMode);
    assign wr_status = wenable_i && (waddr_i == BASE_ADDR + OffStatus);

    assign unused_wdata = ^wdata_i;

    assign ack         = (state_q == StAssert) && reset_irq_i;
    assign vec_onehot  = NUM_CH'(1) << vector_q;
    assign vec_pending = |(pend_q & vec_onehot);
    assign enabled     = pend_q & mask_q;
    assign win_valid   = |enabled;

    // Scan downward so the lowest enabled index is the last one written.
    always_comb begin
        win_idx = 4'd0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (enabled[i]) begin
                win_idx = 4'(i);
            end
        end
    end

    // Set takes precedence over clear, so a held level survives W1C and acknowledge.
    always_comb begin
        set_bits = (mode_q & rise) | (~mode_q & lvl);
        clr_bits = wr_pend ? wdata_i[NUM_CH-1:0] : '0;
        if (ack) begin
            clr_bits = clr_bits | vec_onehot;
        end
        pend_d = (pend_q & ~clr_bits) | set_bits;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pend_q <= '0;
            mask_q <= '0;
            mode_q <= '0;
        end else begin
            pend_q <= pend_d;
            if (wr_mask) begin
                mask_q <= wdata_i[NUM_CH-1:0];
            end
            if (wr_mode) begin
                mode_q <= wdata_i[NUM_CH-1:0];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            irq_q    <= 1'b0;
            vector_q <= 4'd0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (win_valid) begin
                        vector_q <= win_idx;
                        irq_q    <= 1'b1;
                        state_q  <= StAssert;
                    end
                end
                StAssert: begin
                    if (reset_irq_i) begin
                        irq_q   <= 1'b0;
                        state_q <= StService;
                    end else if (!vec_pending) begin
                        irq_q   <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                StService: begin
                    if (wr_status) begin
                        state_q <= StIdle;
                    end
                end
                default: begin
                    irq_q   <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    always_comb begin
        pend_ext = '0;
        mask_ext = '0;
        mode_ext = '0;
        pend_ext[NUM_CH-1:0] = pend_q;
        mask_ext[NUM_CH-1:0] = mask_q;
        mode_ext[NUM_CH-1:0] = mode_q;
        rdata_o = 16'h0000;
        if (raddr_i == BASE_ADDR + OffPending) begin
            rdata_o = pend_ext;
        end else if (raddr_i == BASE_ADDR + OffMask) begin
            rdata_o = mask_ext;
        end else if (raddr_i == BASE_ADDR + OffMode) begin
            rdata_o = mode_ext;
        end else if (raddr_i == BASE_ADDR + OffStatus) begin
            rdata_o = {(state_q == StService), irq_q, 10'b0, vector_q};
        end
    end

    assign irq_o    = irq_q;
    assign vector_o = vector_q;

endmodule

// File: tb/tb_irq_controller.sv
// Self-checking bench for irq_controller: register table, directed handshakes, random vs model.
module tb_irq_controller;

    localparam logic [15:0] BASE = 16'hFF10;
    localparam logic [15:0] CH   = 16'h000F;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  src = '0;
    logic [15:0] waddr = '0, wdata = '0, raddr = '0;
    logic        wenable = 1'b0, reset_irq = 1'b0;
    logic [15:0] rdata;
    logic        irq;
    logic [3:0]  vector;

    int total = 0;
    int bad = 0;

    irq_controller #(.NUM_CH(4), .BASE_ADDR(BASE)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .src_irq_i   (src),
        .waddr_i     (waddr),
        .wdata_i     (wdata),
        .wenable_i   (wenable),
        .raddr_i     (raddr),
        .rdata_o     (rdata),
        .irq_o       (irq),
        .reset_irq_i (reset_irq),
        .vector_o    (vector)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] waddr;
        logic [15:0] wdata;
        logic [15:0] raddr;
        logic [15:0] exp;
    } reg_vec_t;

    reg_vec_t tbl[8];

    // Reference model state: registers as plain vectors, handshake as two flags.
    logic [15:0] m_pend, m_mask, m_mode, m_h0, m_h1, m_h2;
    logic        m_irq, m_serv;
    logic [3:0]  m_vec;

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic rd(input logic [15:0] a, output logic [15:0] d);
        raddr = a;
        #1;
        d = rdata;
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        waddr = a;
        wdata = d;
        wenable = 1'b1;
        tick();
        wenable = 1'b0;
    endtask

    task automatic ack();
        reset_irq = 1'b1;
        tick();
        reset_irq = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        wenable = 1'b0;
        reset_irq = 1'b0;
        ticks(2);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic model_reset();
        m_pend = '0; m_mask = '0; m_mode = '0;
        m_h0 = '0; m_h1 = '0; m_h2 = '0;
        m_irq = 1'b0; m_serv = 1'b0; m_vec = '0;
    endtask

    // Advance the model by one rising edge using the inputs currently applied.
    task automatic model_step();
        logic [15:0] set_v, clr_v, en;
        set_v = ((m_mode & m_h1 & ~m_h2) | (~m_mode & m_h1)) & CH;
        clr_v = (wenable && waddr == BASE) ? wdata : 16'h0;
        en = m_pend & m_mask;
        if (!m_irq && !m_serv) begin
            if (en != 0) begin
                for (int i = 3; i >= 0; i--) if (en[i]) m_vec = 4'(i);
                m_irq = 1'b1;
            end
        end else if (m_irq) begin
            if (reset_irq) begin
                clr_v[m_vec] = 1'b1;
                m_irq = 1'b0;
                m_serv = 1'b1;
            end else if (!m_pend[m_vec]) begin
                m_irq = 1'b0;
            end
        end else if (wenable && waddr == BASE + 16'd3) begin
            m_serv = 1'b0;
        end
        if (wenable && waddr == BASE + 16'd1) m_mask = wdata & CH;
        if (wenable && waddr == BASE + 16'd2) m_mode = wdata & CH;
        m_pend = ((m_pend & ~clr_v) | set_v) & CH;
        m_h2 = m_h1;
        m_h1 = m_h0;
        m_h0 = {12'h0, src};
    endtask

    function automatic logic [15:0] model_read(input logic [15:0] a);
        case (a)
            BASE:          return m_pend;
            BASE + 16'd1:  return m_mask;
            BASE + 16'd2:  return m_mode;
            BASE + 16'd3:  return {m_serv, m_irq, 10'b0, m_vec};
            default:       return 16'h0000;
        endcase
    endfunction

    initial begin
        logic [15:0] d;
        bit seen;

        tbl[0] = '{BASE + 16'd1, 16'hFFFF, BASE + 16'd1, 16'h000F};
        tbl[1] = '{BASE + 16'd2, 16'h00A5, BASE + 16'd2, 16'h0005};
        tbl[2] = '{BASE + 16'd2, 16'h1234, BASE + 16'd2, 16'h0004};
        tbl[3] = '{BASE,         16'hFFFF, BASE,         16'h0000};
        tbl[4] = '{BASE + 16'd4, 16'hFFFF, BASE + 16'd4, 16'h0000};
        tbl[5] = '{BASE + 16'd3, 16'hFFFF, BASE + 16'd3, 16'h0000};
        tbl[6] = '{BASE + 16'd1, 16'h0000, BASE + 16'd1, 16'h0000};
        tbl[7] = '{BASE + 16'd2, 16'h0000, 16'hFF0F,     16'h0000};

        do_reset();
        chk("reset_irq_out", {15'h0, irq}, 16'h0);
        chk("reset_vector", {12'h0, vector}, 16'h0);
        for (int a = 0; a < 4; a++) begin
            rd(BASE + 16'(a), d);
            chk($sformatf("reset_reg%0d", a), d, 16'h0);
        end

        for (int i = 0; i < 8; i++) begin
            wr(tbl[i].waddr, tbl[i].wdata);
            rd(tbl[i].raddr, d);
            chk($sformatf("table%0d", i), d, tbl[i].exp);
            chk($sformatf("table%0d_irq", i), {15'h0, irq}, 16'h0);
        end

        // Edge channel 0: latency, acknowledge, EOI.
        do_reset();
        wr(BASE + 16'd2, 16'h000F);
        wr(BASE + 16'd1, 16'h0001);
        src = 4'b0001;
        ticks(3);
        rd(BASE, d);
        chk("lat_pend_k2", d, 16'h0001);
        chk("lat_irq_k2", {15'h0, irq}, 16'h0);
        tick();
        chk("lat_irq_k3", {15'h0, irq}, 16'h1);
        chk("lat_vec_k3", {12'h0, vector}, 16'h0);
        src = 4'b0000;
        ack();
        chk("ack_irq", {15'h0, irq}, 16'h0);
        rd(BASE, d);
        chk("ack_pend", d, 16'h0000);
        rd(BASE + 16'd3, d);
        chk("ack_status", d, 16'h8000);
        wr(BASE + 16'd3, 16'h0000);
        rd(BASE + 16'd3, d);
        chk("eoi_status", d, 16'h0000);

        // Priority: channels 1 and 3 together.
        do_reset();
        wr(BASE + 16'd2, 16'h000F);
        wr(BASE + 16'd1, 16'h000F);
        src = 4'b1010;
        ticks(4);
        chk("prio_irq", {15'h0, irq}, 16'h1);
        chk("prio_vec1", {12'h0, vector}, 16'h1);
        src = 4'b0000;
        ack();
        wr(BASE + 16'd3, 16'h0000);
        tick();
        chk("prio_reirq", {15'h0, irq}, 16'h1);
        rd(BASE + 16'd3, d);
        chk("prio_status3", d, 16'h4003);

        // Level channel 2: re-assert while held, then W1C after release.
        do_reset();
        wr(BASE + 16'd1, 16'h0004);
        src = 4'b0100;
        ticks(4);
        chk("lvl_irq", {15'h0, irq}, 16'h1);
        chk("lvl_vec", {12'h0, vector}, 16'h2);
        ack();
        rd(BASE, d);
        chk("lvl_pend_held", d, 16'h0004);
        wr(BASE + 16'd3, 16'h0000);
        tick();
        chk("lvl_reirq", {15'h0, irq}, 16'h1);
        src = 4'b0000;
        ack();
        ticks(3);
        wr(BASE, 16'h0004);
        rd(BASE, d);
        chk("lvl_w1c", d, 16'h0000);
        wr(BASE + 16'd3, 16'h0000);
        ticks(2);
        chk("lvl_quiet", {15'h0, irq}, 16'h0);

        // Masked pending, then unmask; then W1C withdraws an asserted request.
        do_reset();
        wr(BASE + 16'd2, 16'h0001);
        src = 4'b0001;
        ticks(4);
        chk("mask_irq0", {15'h0, irq}, 16'h0);
        rd(BASE, d);
        chk("mask_pend", d, 16'h0001);
        wr(BASE + 16'd1, 16'h0001);
        seen = 1'b0;
        for (int i = 0; i < 2 && !seen; i++) begin
            tick();
            seen = irq;
        end
        chk("unmask_irq", {15'h0, seen}, 16'h1);
        wr(BASE, 16'h0001);
        tick();
        chk("w1c_drop_irq", {15'h0, irq}, 16'h0);
        rd(BASE + 16'd3, d);
        chk("w1c_drop_status", d, 16'h0000);
        src = 4'b0000;

        // Reset in the middle of ASSERT discards the request.
        do_reset();
        wr(BASE + 16'd1, 16'h0001);
        src = 4'b0001;
        ticks(4);
        chk("mid_irq_pre", {15'h0, irq}, 16'h1);
        src = 4'b0000;
        rst_n = 1'b0;
        #1;
        chk("mid_irq", {15'h0, irq}, 16'h0);
        for (int a = 0; a < 4; a++) begin
            rd(BASE + 16'(a), d);
            chk($sformatf("mid_reg%0d", a), d, 16'h0);
        end
        tick();
        rst_n = 1'b1;
        tick();
        ack();
        chk("mid_ack_irq", {15'h0, irq}, 16'h0);
        rd(BASE + 16'd3, d);
        chk("mid_ack_status", d, 16'h0000);

        // Randomised run against the reference model.
        src = '0;
        do_reset();
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < 4; b++) if ($urandom_range(15) == 0) src[b] = ~src[b];
            wenable = ($urandom_range(5) == 0);
            waddr = BASE + 16'($urandom_range(4));
            wdata = 16'($urandom);
            reset_irq = ($urandom_range(3) == 0);
            model_step();
            tick();
            chk("rnd_irq", {15'h0, irq}, {15'h0, m_irq});
            chk("rnd_vec", {12'h0, vector}, {12'h0, m_vec});
            rd(BASE + 16'($urandom_range(5)), d);
            chk("rnd_rdata", d, model_read(raddr));
        end
        wenable = 1'b0;
        reset_irq = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
